// File: rtl/l1_icache.sv
// Direct-mapped L1 instruction cache: 64 lines x 16 bytes, filled word 0..3 from instruction memory.
// Define ICACHE_PERF_EN to add saturating perf_hit_cnt / perf_miss_cnt outputs.
module l1_icache (
  input  logic        clk,
  input  logic        rstn,
  input  logic        core_req,
  input  logic [31:0] core_addr,
  output logic [31:0] core_out,
  output logic        core_wait,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_wait
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0] perf_hit_cnt,
  output logic [31:0] perf_miss_cnt
`endif
);
  typedef enum logic [1:0] {IDLE = 2'd0, CHK = 2'd1, FILL = 2'd2} state_e;

  state_e      state_q, state_d;
  logic [31:2] addr_q, addr_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [63:0] valid_q, valid_d;
  logic [21:0] rd_tag_q, rd_tag_d;
  logic        rd_vld_q, rd_vld_d;
  logic [31:0] rd_word_q, rd_word_d;
  logic [31:0] core_out_q, core_out_d;
  logic        mem_req_q, mem_req_d;
  logic [31:0] mem_addr_q, mem_addr_d;

  logic [21:0] tag_mem  [64];
  logic [31:0] data_mem [256];

  logic [5:0]  idx;
  logic [1:0]  cnt_inc;
  logic        hit;
  logic        xfer;
  logic        served;
  logic        unused_addr_lsb;

  assign unused_addr_lsb = ^core_addr[1:0];
  assign idx     = addr_q[9:4];
  assign cnt_inc = cnt_q + 2'd1;
  assign hit     = rd_vld_q && (rd_tag_q == addr_q[31:10]);
  assign xfer    = (state_q == FILL) && !mem_wait;
  assign served  = (state_q == CHK) && hit && core_req;

  assign core_wait = ((state_q == IDLE) && core_req) || ((state_q == CHK) && !hit) || (state_q == FILL);
  assign core_out  = served ? rd_word_q : core_out_q;
  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    valid_d    = valid_q;
    rd_tag_d   = rd_tag_q;
    rd_vld_d   = rd_vld_q;
    rd_word_d  = rd_word_q;
    core_out_d = core_out_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    case (state_q)
      IDLE: begin
        if (core_req) begin
          addr_d    = core_addr[31:2];
          rd_tag_d  = tag_mem[core_addr[9:4]];
          rd_vld_d  = valid_q[core_addr[9:4]];
          rd_word_d = data_mem[{core_addr[9:4], core_addr[3:2]}];
          state_d   = CHK;
        end
      end
      CHK: begin
        if (hit) begin
          if (core_req) core_out_d = rd_word_q;
          state_d = IDLE;
        end else begin
          cnt_d      = 2'd0;
          mem_req_d  = 1'b1;
          mem_addr_d = {addr_q[31:4], 4'b0000};
          state_d    = FILL;
        end
      end
      FILL: begin
        if (!mem_wait) begin
          cnt_d      = cnt_inc;
          mem_addr_d = {addr_q[31:4], cnt_inc, 2'b00};
          // Capture the requested word in flight so the re-check hits without another array read.
          if (cnt_q == addr_q[3:2]) rd_word_d = mem_rdata;
          if (cnt_q == 2'd3) begin
            valid_d[idx] = 1'b1;
            rd_tag_d     = addr_q[31:10];
            rd_vld_d     = 1'b1;
            mem_req_d    = 1'b0;
            state_d      = CHK;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      cnt_q      <= '0;
      valid_q    <= '0;
      rd_tag_q   <= '0;
      rd_vld_q   <= 1'b0;
      rd_word_q  <= '0;
      core_out_q <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      valid_q    <= valid_d;
      rd_tag_q   <= rd_tag_d;
      rd_vld_q   <= rd_vld_d;
      rd_word_q  <= rd_word_d;
      core_out_q <= core_out_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  // Line storage is only trusted through valid_q, so it carries no reset.
  always_ff @(posedge clk) begin
    if (xfer) begin
      data_mem[{idx, cnt_q}] <= mem_rdata;
      if (cnt_q == 2'd3) tag_mem[idx] <= addr_q[31:10];
    end
  end

`ifdef ICACHE_PERF_EN
  logic        refill_q, refill_d;
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  always_comb begin
    refill_d   = refill_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (xfer && (cnt_q == 2'd3)) refill_d = 1'b1;
    else if (state_q == CHK)     refill_d = 1'b0;
    // The post-fill re-check is the tail of a miss, not a hit.
    if (served && !refill_q && (hit_cnt_q != 32'hFFFF_FFFF)) hit_cnt_d = hit_cnt_q + 32'd1;
    if ((state_q == CHK) && !hit && (miss_cnt_q != 32'hFFFF_FFFF)) miss_cnt_d = miss_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      refill_q   <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      refill_q   <= refill_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign perf_hit_cnt  = hit_cnt_q;
  assign perf_miss_cnt = miss_cnt_q;
`endif
endmodule

// File: tb/tb_l1_icache.sv
// Bench for l1_icache: random fetch traffic against a line-level cache model and a synthetic memory.
module tb_l1_icache;
  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        core_req = 1'b0;
  logic [31:0] core_addr = '0;
  logic [31:0] core_out;
  logic        core_wait;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_wait = 1'b0;
`ifdef ICACHE_PERF_EN
  logic [31:0] perf_hit_cnt;
  logic [31:0] perf_miss_cnt;
`endif

  l1_icache dut (
    .clk(clk), .rstn(rstn), .core_req(core_req), .core_addr(core_addr),
    .core_out(core_out), .core_wait(core_wait), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .mem_wait(mem_wait)
`ifdef ICACHE_PERF_EN
    , .perf_hit_cnt(perf_hit_cnt), .perf_miss_cnt(perf_miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Every word address holds a distinct value; garbage is driven while memory is busy.
  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) + 32'h1357_2468;
  endfunction
  assign mem_rdata = mem_wait ? 32'hDEAD_BEEF : mem_fn({mem_addr[31:2], 2'b00});

  // Reference model: which tag each index currently holds.
  bit          m_valid [64];
  logic [21:0] m_tag   [64];
  logic [31:0] last_out = '0;
  int          exp_hits = 0;
  int          exp_misses = 0;

  task automatic clear_model;
    for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
    last_out   = '0;
    exp_hits   = 0;
    exp_misses = 0;
  endtask

  logic        prev_req = 1'b0;
  logic        prev_wait = 1'b0;
  logic [31:0] prev_addr = '0;
  always @(negedge clk) begin
    if (rstn && prev_req && prev_wait && mem_req) chk("mem_addr_hold", mem_addr, prev_addr);
    prev_req  = mem_req & rstn;
    prev_wait = mem_wait;
    prev_addr = mem_addr;
  end

  task automatic do_reset;
    rstn = 1'b0; core_req = 1'b0; mem_wait = 1'b0;
    #1;
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_core_out", core_out, 32'd0);
    chk("rst_core_wait", {31'b0, core_wait}, 32'd0);
    core_req = 1'b1;
    #1;
    chk("rst_core_wait_req", {31'b0, core_wait}, 32'd1);
    core_req = 1'b0;
    clear_model();
    @(negedge clk); rstn = 1'b1;
    @(posedge clk); #1;
  endtask

  // mode: 0 = memory always ready, 1 = random waits, 2 = three wait cycles per word.
  // drop: release core_req right after acceptance.
  task automatic fetch(input logic [31:0] a, input int mode, input bit drop);
    logic [5:0]  idx;
    logic [21:0] tg;
    bit          exp_hit;
    int          cycles, fillc, wcnt;
    bit          done;
    logic [31:0] xa[$];
    logic [31:0] exp_out;
    idx = a[9:4]; tg = a[31:10];
    exp_hit = m_valid[idx] && (m_tag[idx] == tg);
    cycles = 0; fillc = 0; wcnt = 0; done = 1'b0;
    core_req = 1'b1; core_addr = a;
    while (!done && cycles < 300) begin
      if (mode == 2)      mem_wait = mem_req && (wcnt < 3);
      else if (mode == 1) mem_wait = ($urandom_range(0, 2) == 0);
      else                mem_wait = 1'b0;
      @(negedge clk);
      cycles++;
      if (mem_req) begin
        fillc++;
        if (mem_wait) wcnt++;
        else begin
          wcnt = 0;
          xa.push_back(mem_addr);
        end
      end
      if (!core_wait) done = 1'b1;
      else begin
        @(posedge clk); #1;
        if (drop) core_req = 1'b0;
      end
    end
    chk("fetch_done", {31'b0, done}, 32'd1);
    chk("latency", cycles, exp_hit ? 2 : 3 + fillc);
    chk("n_transfers", xa.size(), exp_hit ? 0 : 4);
    foreach (xa[i]) chk("fill_addr", xa[i], {a[31:4], 4'b0000} + 32'(i * 4));
    if (exp_hit)        chk("hit_no_memreq", fillc, 0);
    else if (mode == 0) chk("fill_cycles", fillc, 4);
    else if (mode == 2) chk("fill_cycles_wait", fillc, 16);
    exp_out = drop ? last_out : mem_fn({a[31:2], 2'b00});
    chk("core_out", core_out, exp_out);
    last_out = exp_out;
    if (!exp_hit) begin
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tg;
      exp_misses++;
    end else if (!drop) exp_hits++;
    @(posedge clk); #1;
    core_req = 1'b0; mem_wait = 1'b0;
  endtask

  initial begin
    int n, cyc;
    logic [31:0] a;
    #2;
    do_reset();

    fetch(32'h0000_0104, 0, 0);
    fetch(32'h0000_0108, 0, 0);
    fetch(32'h0000_0100, 0, 0);
    fetch(32'h0000_010C, 0, 0);
    fetch(32'h0000_0504, 0, 0);
    fetch(32'h0000_0104, 0, 0);
    fetch(32'h0000_2208, 2, 0);
    fetch(32'h0000_220C, 0, 0);
    fetch(32'h0000_2200, 0, 1);
    fetch(32'h0000_2204, 0, 0);
    fetch(32'h0001_3340, 1, 1);
    fetch(32'h0001_3344, 0, 0);

    // Abort a fill after its second word; the line must not survive.
    core_req = 1'b1; core_addr = 32'h0000_0700; mem_wait = 1'b0;
    n = 0; cyc = 0;
    while (n < 2 && cyc < 50) begin
      @(negedge clk);
      cyc++;
      if (mem_req && !mem_wait) n++;
      if (n < 2) begin @(posedge clk); #1; end
    end
    chk("midfill_reached", n, 2);
    @(posedge clk); #1;
    chk("pre_rst_mem_req", {31'b0, mem_req}, 32'd1);
    rstn = 1'b0;
    #1;
    chk("rst_mem_req_drop", {31'b0, mem_req}, 32'd0);
    chk("rst_core_out_clr", core_out, 32'd0);
    core_req = 1'b0;
    clear_model();
    @(negedge clk); rstn = 1'b1;
    @(posedge clk); #1;
    fetch(32'h0000_0700, 0, 0);
    fetch(32'h0000_0704, 0, 0);

    for (int k = 0; k < 80; k++) begin
      a = {20'h0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'b00};
      if ($urandom_range(0, 1) == 1) a[31:28] = 4'hA;
      fetch(a, int'($urandom_range(0, 1)), $urandom_range(0, 9) == 0);
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
    end

`ifdef ICACHE_PERF_EN
    do_reset();
    fetch(32'h0000_0104, 0, 0);
    fetch(32'h0000_0108, 0, 0);
    fetch(32'h0000_0504, 0, 0);
    chk("perf_hit_cnt", perf_hit_cnt, exp_hits);
    chk("perf_miss_cnt", perf_miss_cnt, exp_misses);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
